jtag_lock_ctrl: RTL
===================

Name: jtag_lock_ctrl

Overview:
Controller that owns the debug/JTAG write-lock for a protected configuration register. It runs a key-based unlock handshake, counts failed attempts, and enforces a lockout period. It auto-relocks after an idle timeout and gates downstream write requests. The block sits between the debug access port and the protected register; the register's write enable is driven only by wr_grant.

Parameters:
KEY_W, 16, width of unlock key
UNLOCK_KEY, 16'hA5C3, key value that unlocks (KEY_W bits)
MAX_ATTEMPTS, 3, consecutive failed attempts that trigger lockout (>=1)
LOCKOUT_CYCLES, 64, cycles spent in LOCKOUT (>=1)
IDLE_TIMEOUT, 256, idle cycles in UNLOCKED before auto-relock (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  unlock request valid
req_ready  out  1  unlock request can be accepted
req_key  in  KEY_W  key presented with request
relock  in  1  software relock command (level, sampled each cycle)
resp_valid  out  1  one-cycle pulse: unlock attempt result available
resp_ok  out  1  result of attempt; valid only with resp_valid
unlocked  out  1  lock open (registered, equals state==UNLOCKED)
locked_out  out  1  in lockout period
wr_req  in  1  write request to protected register
wr_grant  out  1  write enable to protected register

Behaviour:
- Reset (async assert, sync release): state=LOCKED, fail_cnt=0, key_q=0, timers=0. unlocked=0, wr_grant=0, resp_valid=0, resp_ok=0, locked_out=0. Inputs are ignored while reset_n=0. The lock state is never undefined: LOCKED is the only reset state.
- req_ready = (state==LOCKED). Accept = req_valid & req_ready. Requests arriving in other states are not accepted and not queued; the requester holds req_valid.
- FSM states: LOCKED, CHECK, UNLOCKED, LOCKOUT. Encoding is a 2-bit enum. Any illegal encoding goes to LOCKED.
- LOCKED: on accept in cycle T, key_q<=req_key and go to CHECK (T+1).
- CHECK (exactly 1 cycle, T+1): compare key_q==UNLOCK_KEY. At the end of T+1, resp_valid<=1 for one cycle (T+2), and resp_ok<=match.
  - Match: go to UNLOCKED at T+2, fail_cnt<=0, idle timer<=0.
  - Mismatch with fail_cnt+1==MAX_ATTEMPTS: go to LOCKOUT, lockout counter<=LOCKOUT_CYCLES-1, fail_cnt<=0.
  - Mismatch otherwise: fail_cnt<=fail_cnt+1, return to LOCKED.
- Unlock latency: request accepted at T gives unlocked=1 and resp_valid=1 in cycle T+2.
- UNLOCKED:
  - wr_grant = wr_req & unlocked & ~relock (combinational).
  - A cycle with wr_req=1 clears the idle timer; otherwise the timer increments.
  - relock=1 sends the state to LOCKED next cycle. relock has priority over a simultaneous wr_req, so that cycle's grant is suppressed.
  - When the idle timer reaches IDLE_TIMEOUT-1 with no wr_req, go to LOCKED next cycle.
- relock in LOCKED, CHECK or LOCKOUT has no effect.
- LOCKOUT: locked_out=1 (registered, state==LOCKOUT), req_ready=0. Count down; at 0, go to LOCKED next cycle. relock and wr_req are ignored.
- wr_grant=0 in every state except UNLOCKED.
- Counter widths are $clog2(param+1), saturating never needed. fail_cnt is cleared only on success, on lockout entry, or on reset.
- Reset mid-operation (CHECK, UNLOCKED, LOCKOUT): immediate return to the reset values above. No resp pulse is emitted for an in-flight check.

Decomposition:
- Package jtag_lock_pkg: lock_state_e enum (LOCKED, CHECK, UNLOCKED, LOCKOUT) and default key/timing localparams shared with the protected-register wrapper.
- One sub-module is natural: lock_timer, a loadable down-counter with a done flag. It is instantiated for the LOCKOUT period; the idle timer is inline.

Test Plan:
- Reset value: hold reset_n=0 with req_valid=1 and wr_req=1 -> unlocked=0, wr_grant=0, resp_valid=0, req_ready=1, no transition on release until the next accept.
- Good key: send req_key=16'hA5C3 at T -> resp_valid=1, resp_ok=1 and unlocked=1 at T+2. Then wr_req=1 -> wr_grant=1 in the same cycle.
- Lockout: three wrong keys (16'h0000) -> resp_ok=0 each time. After the third, locked_out=1 for 64 cycles with req_ready=0 and wr_grant=0, then state LOCKED with fail_cnt=0.
- Fail-count reset on success: two wrong keys, then the correct key -> unlocked. Relock, then one wrong key -> no lockout (fail_cnt=1).
- Idle timeout and relock: unlock, then no wr_req for 256 cycles -> unlocked=0 in cycle 257. Separately, relock=1 together with wr_req=1 -> wr_grant=0 and unlocked=0 next cycle.
- Async reset mid-op: assert reset_n=0 in the CHECK cycle and in the middle of LOCKOUT -> outputs return to reset values immediately and no resp_valid pulse appears.

Source files
------------

// File: rtl/jtag_lock_pkg.sv
// Shared lock-state encoding plus the default key and timing values that the
// protected-register wrapper also uses.
package jtag_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    CHECK    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } lock_state_e;

  localparam int          DEF_KEY_W          = 16;
  localparam logic [15:0] DEF_UNLOCK_KEY     = 16'hA5C3;
  localparam int          DEF_MAX_ATTEMPTS   = 3;
  localparam int          DEF_LOCKOUT_CYCLES = 64;
  localparam int          DEF_IDLE_TIMEOUT   = 256;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter. Stops at zero; done is high whenever count is zero.
module lock_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down while enabled, holding at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 count <= '0;
    else if (load)                count <= load_val;
    else if (en && count != '0)   count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/jtag_lock_ctrl.sv
// Debug write-lock controller: key handshake, failed-attempt lockout,
// idle auto-relock and gating of writes to the protected register.
module jtag_lock_ctrl
  import jtag_lock_pkg::*;
#(
  parameter int               KEY_W          = DEF_KEY_W,
  parameter logic [KEY_W-1:0] UNLOCK_KEY     = DEF_UNLOCK_KEY,
  parameter int               MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
  parameter int               LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int               IDLE_TIMEOUT   = DEF_IDLE_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_key,
  input  logic             relock,
  output logic             resp_valid,
  output logic             resp_ok,
  output logic             unlocked,
  output logic             locked_out,
  input  logic             wr_req,
  output logic             wr_grant
);

  localparam int FW = $clog2(MAX_ATTEMPTS + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [FW-1:0] LAST_FAIL = FW'(MAX_ATTEMPTS - 1);
  localparam logic [LW-1:0] LO_LOAD   = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  lock_state_e      state_q, state_d;
  logic [KEY_W-1:0] key_q;
  logic [FW-1:0]    fail_cnt;
  logic [IW-1:0]    idle_cnt;
  logic             accept, key_match, lo_load, lo_done;

  assign req_ready  = (state_q == LOCKED);
  assign accept     = req_valid & req_ready;
  assign key_match  = (key_q == UNLOCK_KEY);
  assign unlocked   = (state_q == UNLOCKED);
  assign locked_out = (state_q == LOCKOUT);
  // relock wins over a same-cycle write.
  assign wr_grant   = wr_req & unlocked & ~relock;

  // Lockout period counter, loaded on the failing CHECK cycle.
  lock_timer #(.W(LW)) u_lockout (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (lo_load),
    .en       (locked_out),
    .load_val (LO_LOAD),
    .done     (lo_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= LOCKED;
    else          state_q <= state_d;
  end

  // Next-state logic and lockout timer load.
  always_comb begin
    state_d = state_q;
    lo_load = 1'b0;
    case (state_q)
      LOCKED:   if (accept) state_d = CHECK;
      CHECK: begin
        if (key_match)                  state_d = UNLOCKED;
        else if (fail_cnt == LAST_FAIL) begin
          state_d = LOCKOUT;
          lo_load = 1'b1;
        end
        else                            state_d = LOCKED;
      end
      UNLOCKED: begin
        if (relock)                              state_d = LOCKED;
        else if (!wr_req && idle_cnt == IDLE_LAST) state_d = LOCKED;
      end
      LOCKOUT:  if (lo_done) state_d = LOCKED;
      default:  state_d = LOCKED;
    endcase
  end

  // Key capture, attempt counting, idle timer and the one-cycle response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q      <= '0;
      fail_cnt   <= '0;
      idle_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_ok    <= 1'b0;
    end else begin
      resp_valid <= (state_q == CHECK);
      resp_ok    <= (state_q == CHECK) & key_match;
      if (accept) key_q <= req_key;
      if (state_q == CHECK) begin
        idle_cnt <= '0;
        if (key_match || fail_cnt == LAST_FAIL) fail_cnt <= '0;
        else                                    fail_cnt <= fail_cnt + 1'b1;
      end else if (state_q == UNLOCKED) begin
        if (wr_req) idle_cnt <= '0;
        else        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule
